apb_master_param: RTL

APB_MASTER_PARAM -- requirements
Module: apb_master_param

---
 rtl/apb_master_param.sv | 107 ++++++++++
 1 files changed

// File: rtl/apb_master_param.sv
// rtl/apb_master_param.sv - parameterised APB master with command handshake, wait-state timeout and response pulse
module apb_master_param #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                Pclk,
  input  logic                Presetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic                cmd_wr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                Psel,
  output logic                Penable,
  output logic                Pwrite,
  output logic [ADDR_W-1:0]   Paddr,
  output logic [DATA_W-1:0]   PWdata,
  output logic [DATA_W/8-1:0] Pstrb,
  input  logic [DATA_W-1:0]   PRdata,
  input  logic                Pready,
  input  logic                Pslverr
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          expire;
  logic          complete;
  logic          accept;

  // The TIMEOUT-th consecutive not-ready ACCESS cycle ends the transfer; a late Pready still wins.
  assign expire    = (state == ACCESS) && !Pready && (wait_cnt == CW'(TIMEOUT - 1));
  assign complete  = (state == ACCESS) && (Pready || expire);
  assign cmd_ready = (state == IDLE) || complete;
  assign accept    = cmd_valid && cmd_ready;

  // Transfer sequencing, APB bus drive and one-cycle response generation.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      Psel        <= 1'b0;
      Penable     <= 1'b0;
      Pwrite      <= 1'b0;
      Paddr       <= '0;
      PWdata      <= '0;
      Pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= complete;
      rsp_err     <= complete && (expire || Pslverr);
      rsp_timeout <= expire;
      rsp_rdata   <= (complete && Pready && !Pslverr && !Pwrite) ? PRdata : '0;

      if (accept) begin
        state   <= SETUP;
        Psel    <= 1'b1;
        Penable <= 1'b0;
        Paddr   <= cmd_addr;
        Pwrite  <= cmd_wr;
        PWdata  <= cmd_wr ? cmd_wdata : '0;
        Pstrb   <= cmd_wr ? cmd_strb : '0;
      end else begin
        case (state)
          SETUP: begin
            state    <= ACCESS;
            Penable  <= 1'b1;
            wait_cnt <= '0;
          end
          ACCESS: begin
            if (complete) begin
              state   <= IDLE;
              Psel    <= 1'b0;
              Penable <= 1'b0;
              Pwrite  <= 1'b0;
              PWdata  <= '0;
              Pstrb   <= '0;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end
          default: begin
            state   <= IDLE;
            Psel    <= 1'b0;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            PWdata  <= '0;
            Pstrb   <= '0;
          end
        endcase
      end
    end
  end

endmodule
